// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control unit. Sequences each instruction through
// fetch/decode/execute/memory/writeback, handshakes with memory through
// mem_ready, resolves branch conditions, traps unknown encodings and
// counts retired instructions.
`timescale 1ns/1ps
module multicycle_control #(
    parameter int CNT_W   = 32,
    parameter bit TRAP_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             lt,
    input  logic             ltu,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_LUI       = 4'd12,
        S_AUIPC     = 4'd13,
        S_ILLEGAL   = 4'd14
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t cur;
    state_t nxt;

    // Branch outcome from the ALU flags; unsupported funct3 codes never take.
    function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                          input logic slt, input logic ult);
        case (f3)
            3'b000:  return z;
            3'b001:  return ~z;
            3'b100:  return slt;
            3'b101:  return ~slt;
            3'b110:  return ult;
            3'b111:  return ~ult;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic branch_legal(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

    assign state = cur;

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur <= S_FETCH;
        else       cur <= nxt;
    end

    // Retired-instruction counter: one count per arrival back in FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               instret <= '0;
        else if (nxt == S_FETCH && cur != S_FETCH) instret <= instret + 1'b1;
    end

    // Next-state and output decode; outputs are forced low while reset is high.
    always_comb begin
        nxt        = cur;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        illegal    = 1'b0;
        case (cur)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALUOut captures old_pc + imm as the branch/jal target.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                case (op)
                    OP_R:               nxt = S_EXEC_R;
                    OP_I:               nxt = S_EXEC_I;
                    OP_LOAD, OP_STORE:  nxt = S_MEM_ADDR;
                    OP_BRANCH:          nxt = S_BRANCH;
                    OP_JAL:             nxt = S_JAL;
                    OP_JALR:            nxt = S_JALR;
                    OP_LUI:             nxt = S_LUI;
                    OP_AUIPC:           nxt = S_AUIPC;
                    default:            nxt = TRAP_EN ? S_ILLEGAL : S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b10;
                nxt       = (op == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) nxt = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
                nxt        = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) nxt = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b11;
                alu_op    = 2'b10;
                nxt       = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
                nxt       = S_ALU_WB;
            end
            S_LUI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                nxt       = S_ALU_WB;
            end
            S_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                nxt       = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                nxt       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b11;
                alu_op    = 2'b01;
                pc_src    = 1'b1;
                pc_write  = branch_legal(funct3) && branch_taken(funct3, zero, lt, ltu);
                nxt       = (!branch_legal(funct3) && TRAP_EN) ? S_ILLEGAL : S_FETCH;
            end
            S_JAL: begin
                // PC already holds pc+4 from fetch, so it is the link value.
                pc_write   = 1'b1;
                pc_src     = 1'b1;
                reg_write  = 1'b1;
                result_src = 2'b10;
                nxt        = S_FETCH;
            end
            S_JALR: begin
                // rd takes the pre-edge PC while PC loads rs1 + imm.
                alu_src_a  = 2'b11;
                alu_src_b  = 2'b10;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                result_src = 2'b10;
                nxt        = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
                nxt     = S_ILLEGAL;
            end
            default: nxt = S_FETCH;
        endcase
        if (reset) begin
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            i_or_d     = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 1'b0;
            reg_write  = 1'b0;
            result_src = 2'b00;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            illegal    = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Next-generation control unit for the RISC-V core: a multi-cycle FSM that replaces the single-cycle opcode decoder.
- Sequences each RV32I instruction through fetch, decode, execute, memory and writeback states.
- Drives the shared-memory multi-cycle datapath, and handshakes with memory through mem_ready.
- Adds branch-condition resolution for all six B-type funct3 codes, illegal-opcode trapping, and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of instret counter; wraps modulo 2^CNT_W.
- TRAP_EN, 1, 1: unknown opcode or funct3 enters sticky ILLEGAL; 0: treated as NOP, returns to FETCH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  7  instr[6:0] from instruction register.
- funct3  in  3  instr[14:12].
- zero  in  1  ALU result == 0.
- lt  in  1  ALU signed less-than flag.
- ltu  in  1  ALU unsigned less-than flag.
- mem_ready  in  1  memory completes the current read/write this cycle.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- i_or_d  out  1  memory address select: 0 PC, 1 ALUOut.
- ir_write  out  1  load IR and old_pc.
- pc_write  out  1  PC enable.
- pc_src  out  1  PC input: 0 ALU result, 1 ALUOut register.
- reg_write  out  1  register file write enable.
- result_src  out  2  writeback select: 00 ALUOut, 01 memory data, 10 PC.
- alu_src_a  out  2  00 PC, 01 old_pc, 10 zero, 11 rs1.
- alu_src_b  out  2  00 rs2, 01 const 4, 10 immediate.
- alu_op  out  2  00 ADD, 01 SUB/compare, 10 R-type funct decode, 11 I-type funct decode.
- illegal  out  1  sticky illegal-instruction flag.
- state  out  4  current state encoding, for debug.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- States (encoding 0–14): FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, JALR, LUI, AUIPC, ILLEGAL.
- Reset (async): state=FETCH, instret=0, illegal=0, all strobes 0 while reset is high; select outputs 0.
- Outputs decode combinationally from state. pc_write in BRANCH and all mem_ready-qualified strobes are Mealy.
- FETCH: mem_read=1, i_or_d=0, a=00, b=01, alu_op=00, pc_src=0.
  - If mem_ready: ir_write=1, pc_write=1, next DECODE.
  - Else hold; outputs stable.
- DECODE: a=01, b=10, alu_op=00; ALUOut gets the branch/jal target. Next state by op:
  - 0110011 → EXEC_R; 0010011 → EXEC_I; 0000011 or 0100011 → MEM_ADDR.
  - 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR; 0110111 → LUI; 0010111 → AUIPC.
  - Any other op → ILLEGAL (TRAP_EN=1) or FETCH (TRAP_EN=0).
- MEM_ADDR: a=11, b=10, alu_op=00. Next MEM_READ if op=0000011, else MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, result_src=01 → FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Hold until mem_ready, then FETCH.
- EXEC_R: a=11, b=00, alu_op=10 → ALU_WB.
- EXEC_I: a=11, b=10, alu_op=11 → ALU_WB.
- LUI: a=10, b=10, alu_op=00 → ALU_WB.
- AUIPC: a=01, b=10, alu_op=00 → ALU_WB.
- ALU_WB: reg_write=1, result_src=00 → FETCH.
- BRANCH: a=11, b=00, alu_op=01, pc_src=1. pc_write = taken, where taken per funct3 is:
  - 000 zero; 001 ~zero; 100 lt; 101 ~lt; 110 ltu; 111 ~ltu.
  - funct3 010/011 → ILLEGAL (TRAP_EN=1), else FETCH with no PC write.
- JAL: pc_write=1, pc_src=1, reg_write=1, result_src=10 (PC already holds pc+4) → FETCH.
- JALR: a=11, b=10, alu_op=00, pc_src=0, pc_write=1, reg_write=1, result_src=10 → FETCH. Same-edge update of rd and PC is legal (rd captures pre-edge PC); the datapath clears bit 0.
- ILLEGAL: illegal=1, all strobes 0. Absorbing state; exit only on reset.
- instret increments by 1 on every transition into FETCH from any state other than FETCH itself, i.e. one per retired instruction including NOP-treated ops. Wraps all-ones → 0.
- Cycle counts at zero wait (mem_ready tied high): R/I/LUI/AUIPC 4; lw 5; sw 4; branch 3; jal/jalr 3. Each mem_ready-low cycle adds exactly one cycle.
- Reset mid-instruction (including during a stalled memory access) aborts immediately; mem_read/mem_write drop in the same cycle.

Test Plan:
- mem_ready=1; IR sequence add, addi, lui, auipc → each takes 4 cycles; state trace 0,1,6/7/12/13,8,0; instret=4 after 16 cycles.
- lw with mem_ready low 3 cycles in MEM_READ → mem_read/i_or_d=1 held 4 cycles, reg_write with result_src=01 in MEM_WB; total 8 cycles; sw with zero wait → 4 cycles, mem_write exactly 1 cycle.
- beq/bne/blt/bge/bltu/bgeu with zero, lt, ltu each driven 0 and 1 → pc_write in BRANCH matches the taken table for all 12 cases; funct3=010 → illegal=1, state=14, strobes 0.
- jal then jalr → 3 cycles each; pc_write=reg_write=1 with result_src=10 in the final state; pc_src 1 vs 0 respectively.
- op=7'b1111111 with TRAP_EN=1 → ILLEGAL, sticky through 10 cycles; with TRAP_EN=0 → back to FETCH after DECODE, instret+1.
- CNT_W=4: retire 17 instructions → instret=1. Assert reset mid-MEM_READ → outputs 0 asynchronously, state=0, instret=0.
